// File: rtl/cubehash_share_arb_if.sv
// Bundle of source FIFO, destination FIFO and CubeHash core signals served by
// cubehash_share_arb; master is the arbiter side, slave the surrounding datapath.
interface cubehash_share_arb_if #(
  parameter int unsigned DATA_WIDTH = 256
);
  logic                  src0_empty;
  logic [DATA_WIDTH-1:0] src0_dout;
  logic                  src0_rd_en;
  logic                  src1_empty;
  logic [DATA_WIDTH-1:0] src1_dout;
  logic                  src1_rd_en;
  logic                  dst0_full;
  logic                  dst0_wr_en;
  logic [DATA_WIDTH-1:0] dst0_din;
  logic                  dst1_full;
  logic                  dst1_wr_en;
  logic [DATA_WIDTH-1:0] dst1_din;
  logic                  core_start;
  logic [DATA_WIDTH-1:0] core_din;
  logic                  core_done;
  logic [DATA_WIDTH-1:0] core_dout;

  modport master (
    input  src0_empty, src0_dout, src1_empty, src1_dout,
    input  dst0_full, dst1_full, core_done, core_dout,
    output src0_rd_en, src1_rd_en, dst0_wr_en, dst0_din,
    output dst1_wr_en, dst1_din, core_start, core_din
  );

  modport slave (
    output src0_empty, src0_dout, src1_empty, src1_dout,
    output dst0_full, dst1_full, core_done, core_dout,
    input  src0_rd_en, src1_rd_en, dst0_wr_en, dst0_din,
    input  dst1_wr_en, dst1_din, core_start, core_din
  );
endinterface

// File: rtl/cubehash_share_arb.sv
// Shares one iterative CubeHash-256 core between two requesters (keccak->lyra2, skein->bmw).
// Define CUBE_ARB_DRAIN_PRIO_EN for fixed priority to requester 1; default is round-robin.
module cubehash_share_arb #(
  parameter int unsigned DATA_WIDTH     = 256,
  parameter int unsigned CNT_WIDTH      = 32,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic                 clk,
  input  logic                 rst,
  cubehash_share_arb_if.master bus,
  output logic                 grant_id,
  output logic [CNT_WIDTH-1:0] hash_cnt0,
  output logic [CNT_WIDTH-1:0] hash_cnt1,
  output logic [1:0]           err
);
  localparam int unsigned WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {S_IDLE, S_RD, S_LD, S_START, S_RUN, S_WR} state_t;

  state_t                state_q, state_d;
  logic                  grant_q, grant_d, last_q, last_d;
  logic                  rd0_q, rd0_d, rd1_q, rd1_d, start_q, start_d;
  logic                  wr0_q, wr0_d, wr1_q, wr1_d;
  logic [DATA_WIDTH-1:0] din_q, din_d, dout0_q, dout0_d, dout1_q, dout1_d;
  logic [CNT_WIDTH-1:0]  cnt0_q, cnt0_d, cnt1_q, cnt1_d;
  logic [1:0]            err_q, err_d;
  logic [WD_W-1:0]       wd_q, wd_d;
  logic                  req0, req1, win, dst_full_g, do_wr;

  assign req0       = !bus.src0_empty && !bus.dst0_full;
  assign req1       = !bus.src1_empty && !bus.dst1_full;
  assign dst_full_g = grant_q ? bus.dst1_full : bus.dst0_full;

`ifdef CUBE_ARB_DRAIN_PRIO_EN
  assign win = req1;
`else
  assign win = (req0 && req1) ? !last_q : req1;
`endif

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    rd0_d   = 1'b0;
    rd1_d   = 1'b0;
    start_d = 1'b0;
    wr0_d   = 1'b0;
    wr1_d   = 1'b0;
    din_d   = din_q;
    dout0_d = dout0_q;
    dout1_d = dout1_q;
    cnt0_d  = cnt0_q;
    cnt1_d  = cnt1_q;
    err_d   = err_q;
    wd_d    = wd_q;
    do_wr   = 1'b0;

    if (bus.core_done && state_q != S_RUN) err_d[1] = 1'b1;

    unique case (state_q)
      S_IDLE: if (req0 || req1) begin
        grant_d = win;
        rd0_d   = !win;
        rd1_d   = win;
        state_d = S_RD;
      end
      S_RD: state_d = S_LD;
      S_LD: begin
        din_d   = grant_q ? bus.src1_dout : bus.src0_dout;
        start_d = 1'b1;
        state_d = S_START;
      end
      S_START: begin
        wd_d    = '0;
        state_d = S_RUN;
      end
      S_RUN: begin
        if (bus.core_done) begin
          if (grant_q) dout1_d = bus.core_dout;
          else         dout0_d = bus.core_dout;
          do_wr   = !dst_full_g;
          state_d = S_WR;
        end else if (TIMEOUT_CYCLES != 0 && wd_q == WD_LAST) begin
          err_d[0] = 1'b1;
          state_d  = S_IDLE;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      // The write strobe is registered on entry to WR; WR only lingers if the dst was full then.
      S_WR: begin
        if (wr0_q || wr1_q) state_d = S_IDLE;
        else                do_wr   = !dst_full_g;
      end
      default: state_d = S_IDLE;
    endcase

    if (do_wr) begin
      last_d = grant_q;
      if (grant_q) begin
        wr1_d  = 1'b1;
        cnt1_d = cnt1_q + 1'b1;
      end else begin
        wr0_d  = 1'b1;
        cnt0_d = cnt0_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      grant_q <= 1'b0;
      last_q  <= 1'b1;
      rd0_q   <= 1'b0;
      rd1_q   <= 1'b0;
      start_q <= 1'b0;
      wr0_q   <= 1'b0;
      wr1_q   <= 1'b0;
      din_q   <= '0;
      dout0_q <= '0;
      dout1_q <= '0;
      cnt0_q  <= '0;
      cnt1_q  <= '0;
      err_q   <= '0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      rd0_q   <= rd0_d;
      rd1_q   <= rd1_d;
      start_q <= start_d;
      wr0_q   <= wr0_d;
      wr1_q   <= wr1_d;
      din_q   <= din_d;
      dout0_q <= dout0_d;
      dout1_q <= dout1_d;
      cnt0_q  <= cnt0_d;
      cnt1_q  <= cnt1_d;
      err_q   <= err_d;
      wd_q    <= wd_d;
    end
  end

  assign bus.src0_rd_en = rd0_q;
  assign bus.src1_rd_en = rd1_q;
  assign bus.core_start = start_q;
  assign bus.core_din   = din_q;
  assign bus.dst0_wr_en = wr0_q;
  assign bus.dst1_wr_en = wr1_q;
  assign bus.dst0_din   = dout0_q;
  assign bus.dst1_din   = dout1_q;
  assign grant_id       = grant_q;
  assign hash_cnt0      = cnt0_q;
  assign hash_cnt1      = cnt1_q;
  assign err            = err_q;
endmodule

// File: tb/tb_cubehash_share_arb.sv
// Directed bench for cubehash_share_arb: behavioural source FIFOs and a fixed-latency
// core model (digest = message ^ MASK) drive the arbiter through its job sequence.
module tb_cubehash_share_arb;
  localparam int unsigned DW  = 256;
  localparam int unsigned CW  = 32;
  localparam int unsigned TO  = 64;
  localparam int          LAT = 10;
  localparam logic [DW-1:0] MASK = {8{32'h5EED_C0BE}};

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          grant_id;
  logic [CW-1:0] hash_cnt0, hash_cnt1;
  logic [1:0]    err;

  always #5 clk = ~clk;

  cubehash_share_arb_if #(.DATA_WIDTH(DW)) bus ();

  cubehash_share_arb #(
    .DATA_WIDTH(DW),
    .CNT_WIDTH(CW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .grant_id(grant_id),
    .hash_cnt0(hash_cnt0),
    .hash_cnt1(hash_cnt1),
    .err(err)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [DW-1:0] q0[$];
  logic [DW-1:0] q1[$];
  logic p_rd0 = 1'b0;
  logic p_rd1 = 1'b0;
  logic core_en = 1'b1;
  int pending = 0;
  logic [DW-1:0] core_in_lat = '0;
  logic [DW-1:0] st_din = '0;
  int rd_cyc = -1, rd_id = -1, st_cyc = -1, done_cyc = -1, err0_cyc = -1, n_rd = 0;
  int wr_cyc[$];
  int wr_dst[$];
  int wr_gnt[$];
  logic [DW-1:0] wr_dat[$];

`ifdef CUBE_ARB_DRAIN_PRIO_EN
  int exp_seq[8] = '{1, 1, 1, 1, 0, 0, 0, 0};
`else
  int exp_seq[8] = '{0, 1, 0, 1, 0, 1, 0, 1};
`endif

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One clock: react to last cycle's strobes, then sample this cycle's outputs.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (p_rd0 && q0.size() > 0) bus.src0_dout = q0.pop_front();
    if (p_rd1 && q1.size() > 0) bus.src1_dout = q1.pop_front();
    bus.src0_empty = (q0.size() == 0);
    bus.src1_empty = (q1.size() == 0);
    bus.core_done = 1'b0;
    if (pending > 0) begin
      pending--;
      if (pending == 0) begin
        bus.core_done = 1'b1;
        bus.core_dout = core_in_lat ^ MASK;
        done_cyc = cyc;
      end
    end
    p_rd0 = bus.src0_rd_en;
    p_rd1 = bus.src1_rd_en;
    if (p_rd0 || p_rd1) begin
      n_rd++;
      rd_cyc = cyc;
      rd_id = p_rd1 ? 1 : 0;
    end
    if (bus.core_start) begin
      st_cyc = cyc;
      st_din = bus.core_din;
      if (core_en) begin
        pending = LAT;
        core_in_lat = bus.core_din;
      end
    end
    if (bus.dst0_wr_en) begin
      wr_cyc.push_back(cyc); wr_dst.push_back(0); wr_gnt.push_back(int'(grant_id)); wr_dat.push_back(bus.dst0_din);
    end
    if (bus.dst1_wr_en) begin
      wr_cyc.push_back(cyc); wr_dst.push_back(1); wr_gnt.push_back(int'(grant_id)); wr_dat.push_back(bus.dst1_din);
    end
    if (err[0] && err0_cyc < 0) err0_cyc = cyc;
  endtask

  task automatic clr();
    wr_cyc.delete(); wr_dst.delete(); wr_gnt.delete(); wr_dat.delete();
    n_rd = 0; rd_cyc = -1; st_cyc = -1; done_cyc = -1;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    pending = 0;
    repeat (n) step();
    rst = 1'b0;
  endtask

  task automatic wait_wr(input string tag, input int n, input int budget);
    int b = budget;
    while (wr_dat.size() < n && b > 0) begin
      step();
      b--;
    end
    check(tag, DW'(wr_dat.size()), DW'(n));
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1);
  end

  initial begin
    int p, b, i0, i1, bad;
    logic [DW-1:0] a, w;
    bus.src0_empty = 1'b1; bus.src1_empty = 1'b1;
    bus.src0_dout = '0;    bus.src1_dout = '0;
    bus.dst0_full = 1'b0;  bus.dst1_full = 1'b0;
    bus.core_done = 1'b0;  bus.core_dout = '0;

    // Reset and quiet idle
    do_reset(2);
    check("rst_grant", DW'(grant_id), '0);
    check("rst_cnt0", DW'(hash_cnt0), '0);
    check("rst_cnt1", DW'(hash_cnt1), '0);
    check("rst_err", DW'(err), '0);
    check("rst_core_din", bus.core_din, '0);
    check("rst_dst_din", bus.dst0_din | bus.dst1_din, '0);
    bad = 0;
    repeat (10) begin
      step();
      if (bus.src0_rd_en || bus.src1_rd_en || bus.core_start || bus.dst0_wr_en || bus.dst1_wr_en) bad++;
    end
    check("rst_quiet", DW'(bad), '0);

    // Single job on requester 0
    clr();
    a = 256'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210_DEAD_BEEF_CAFE_F00D_1357_9BDF_2468_ACE0;
    q0.push_back(a); bus.src0_empty = 1'b0; p = cyc;
    wait_wr("t2_wait", 1, 40);
    check("t2_rd_cyc", DW'(rd_cyc), DW'(p + 1));
    check("t2_rd_id", DW'(rd_id), '0);
    check("t2_n_rd", DW'(n_rd), DW'(1));
    check("t2_start_cyc", DW'(st_cyc), DW'(p + 3));
    check("t2_core_din", st_din, a);
    check("t2_done_lat", DW'(done_cyc), DW'(st_cyc + LAT));
    if (wr_dat.size() > 0) begin
      check("t2_wr_cyc", DW'(wr_cyc[0]), DW'(done_cyc + 1));
      check("t2_wr_dst", DW'(wr_dst[0]), '0);
      check("t2_wr_dat", wr_dat[0], a ^ MASK);
    end
    check("t2_cnt0", DW'(hash_cnt0), DW'(1));
    check("t2_cnt1", DW'(hash_cnt1), '0);

    // Fresh reset so arbitration history is the reset value
    do_reset(1);
    check("rst2_cnt0", DW'(hash_cnt0), '0);

    // Tie: both sources hold 4 words
    clr();
    for (int i = 0; i < 4; i++) begin
      w = DW'(32'hA000_0000 + i); q0.push_back(w);
      w = DW'(32'hB000_0000 + i); q1.push_back(w);
    end
    bus.src0_empty = 1'b0; bus.src1_empty = 1'b0;
    wait_wr("t3_wait", 8, 250);
    i0 = 0; i1 = 0;
    for (int k = 0; k < 8 && k < wr_dat.size(); k++) begin
      check($sformatf("t3_seq%0d", k), DW'(wr_dst[k]), DW'(exp_seq[k]));
      check($sformatf("t3_gnt%0d", k), DW'(wr_gnt[k]), DW'(exp_seq[k]));
      if (exp_seq[k] == 0) begin
        w = DW'(32'hA000_0000 + i0); i0++;
      end else begin
        w = DW'(32'hB000_0000 + i1); i1++;
      end
      check($sformatf("t3_dat%0d", k), wr_dat[k], w ^ MASK);
    end
    check("t3_cnt0", DW'(hash_cnt0), DW'(4));
    check("t3_cnt1", DW'(hash_cnt1), DW'(4));

    // Backpressure on dst1
    repeat (3) step();
    clr();
    bus.dst1_full = 1'b1;
    a = DW'(64'hC0C0_1111_2222_3333);
    q1.push_back(a); bus.src1_empty = 1'b0;
    repeat (50) step();
    check("t4_no_rd", DW'(n_rd), '0);
    bus.dst1_full = 1'b0; p = cyc;
    wait_wr("t4_wait", 1, 40);
    check("t4_rd_cyc", DW'(rd_cyc), DW'(p + 1));
    check("t4_rd_id", DW'(rd_id), DW'(1));
    if (wr_dat.size() > 0) check("t4_wr_dat", wr_dat[0], a ^ MASK);
    check("t4_cnt1", DW'(hash_cnt1), DW'(5));

    // Watchdog: core never answers
    repeat (3) step();
    clr();
    core_en = 1'b0; err0_cyc = -1;
    a = DW'(64'hE0E0_4444_5555_6666);
    q0.push_back(a); bus.src0_empty = 1'b0;
    b = 120;
    while (err0_cyc < 0 && b > 0) begin step(); b--; end
    check("t5_err0_seen", DW'(err0_cyc >= 0), DW'(1));
    check("t5_err_cyc", DW'(err0_cyc), DW'(st_cyc + int'(TO) + 1));
    check("t5_err", DW'(err), DW'(2'b01));
    repeat (5) step();
    check("t5_no_wr", DW'(wr_dat.size()), '0);
    check("t5_cnt0", DW'(hash_cnt0), DW'(4));
    core_en = 1'b1;
    clr();
    a = DW'(64'hF0F0_7777_8888_9999);
    q0.push_back(a); bus.src0_empty = 1'b0; p = cyc;
    wait_wr("t5_next_wait", 1, 40);
    check("t5_next_rd_cyc", DW'(rd_cyc), DW'(p + 1));
    if (wr_dat.size() > 0) check("t5_next_dat", wr_dat[0], a ^ MASK);
    check("t5_next_cnt0", DW'(hash_cnt0), DW'(5));
    check("t5_err_hold", DW'(err), DW'(2'b01));

    // Reset in the middle of RUN, then a stray core_done
    repeat (3) step();
    clr();
    a = DW'(64'h1234_ABCD_0000_5555);
    q0.push_back(a); bus.src0_empty = 1'b0;
    b = 20;
    while (st_cyc < 0 && b > 0) begin step(); b--; end
    check("t6_started", DW'(st_cyc >= 0), DW'(1));
    repeat (3) step();
    do_reset(1);
    repeat (20) step();
    check("t6_no_wr", DW'(wr_dat.size()), '0);
    check("t6_cnt0", DW'(hash_cnt0), '0);
    check("t6_cnt1", DW'(hash_cnt1), '0);
    check("t6_err_clr", DW'(err), '0);
    bus.core_done = 1'b1;
    step();
    check("t6_err_stray", DW'(err), DW'(2'b10));
    step();
    check("t6_no_wr2", DW'(wr_dat.size()), '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
